// File: rtl/auc_pkg.sv
// auc_pkg: constants shared by the AUC host loader and decoder.
// Holds mode encodings, operand-count lookup and loader state type.
package auc_pkg;

  localparam int AUC_WIDTH = 256;
  localparam int AUC_BUS   = 32;
  localparam int AUC_DEPTH = 4;
  localparam int AUC_BEATS = AUC_WIDTH / AUC_BUS;

  localparam logic [2:0] MODE_RAND = 3'b000;
  localparam logic [2:0] MODE_INVS = 3'b001;
  localparam logic [2:0] MODE_R    = 3'b010;
  localparam logic [2:0] MODE_S    = 3'b011;
  localparam logic [2:0] MODE_MMUL = 3'b101;

  typedef struct packed {
    logic       legal;
    logic [2:0] n;
  } opcnt_t;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } ldr_state_t;

  function automatic opcnt_t auc_opcnt(input logic [2:0] mode);
    opcnt_t r;
    r.legal = 1'b1;
    r.n     = 3'd0;
    case (mode)
      MODE_RAND: r.n = 3'd0;
      MODE_INVS: r.n = 3'd0;
      MODE_R:    r.n = 3'd0;
      MODE_S:    r.n = 3'd2;
      MODE_MMUL: r.n = 3'd4;
      default:   r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/auc_wbuf.sv
// auc_wbuf: beat assembly register and operand buffer.
// Beats arrive LSW first; a full word lands in buf[wcnt].
module auc_wbuf
  import auc_pkg::*;
#(
  parameter int WIDTH = AUC_WIDTH,
  parameter int BUS   = AUC_BUS,
  parameter int DEPTH = AUC_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          beat_en,
  input  logic [BUS-1:0]                beat_dat,
  input  logic                          clr,
  input  logic [$clog2(DEPTH)-1:0]      rd_idx,
  output logic [WIDTH-1:0]              rd_dat,
  output logic [$clog2(WIDTH/BUS)-1:0]  bcnt,
  output logic [$clog2(DEPTH+1)-1:0]    wcnt
);

  localparam int BW = $clog2(WIDTH / BUS);
  localparam int WW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH / BUS - 1);

  logic [WIDTH-1:0] asm_q, asm_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [WIDTH-1:0] word;
  logic             wr_en;

  // shift beats in from the top; the last beat completes a word
  always_comb begin
    asm_d  = asm_q;
    bcnt_d = bcnt_q;
    wcnt_d = wcnt_q;
    word   = {beat_dat, asm_q[WIDTH-1:BUS]};
    wr_en  = beat_en && !clr && (bcnt_q == BLAST);
    if (clr) begin
      bcnt_d = '0;
      wcnt_d = '0;
    end else if (beat_en) begin
      asm_d  = word;
      bcnt_d = bcnt_q + BW'(1);
      if (wr_en) wcnt_d = wcnt_q + WW'(1);
    end
  end

  // counters and assembly register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q  <= '0;
      bcnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      asm_q  <= asm_d;
      bcnt_q <= bcnt_d;
      wcnt_q <= wcnt_d;
    end
  end

  // operand store, written only with complete words
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wcnt_q[IW-1:0]] <= word;
    end
  end

  assign rd_dat = buf_q[rd_idx];
  assign bcnt   = bcnt_q;
  assign wcnt   = wcnt_q;

endmodule

// File: rtl/auc_loader.sv
// auc_loader: gathers host operands and plays them to the decoder
// as one contiguous auc_start burst with auc_mode held afterwards.
module auc_loader
  import auc_pkg::*;
#(
  parameter int WIDTH = AUC_WIDTH,
  parameter int BUS   = AUC_BUS,
  parameter int DEPTH = AUC_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_wr,
  input  logic [BUS-1:0]   host_wdat,
  output logic             host_rdy,
  input  logic             host_cmd_vld,
  input  logic [2:0]       host_cmd_mode,
  output logic             host_cmd_rdy,
  input  logic             core_busy,
  output logic [WIDTH-1:0] auc_dat,
  output logic             auc_start,
  output logic [2:0]       auc_mode,
  output logic             ldr_busy,
  output logic             ldr_err
);

  localparam int BW = $clog2(WIDTH / BUS);
  localparam int WW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  ldr_state_t       state_q, state_d;
  logic [IW-1:0]    kcnt_q, kcnt_d;
  logic             hold_q, hold_d;
  logic [2:0]       mode_q, mode_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  logic [BW-1:0]    bcnt;
  logic [WW-1:0]    wcnt;
  logic [IW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_dat;
  logic             beat_en;
  logic             clr;
  logic             cmd_fire;
  logic             cmd_ok;
  opcnt_t           op_cmd;
  opcnt_t           op_cur;
  logic [2:0]       last3;
  logic [IW-1:0]    klast;

  assign host_rdy     = (state_q == ST_LOAD) &&
                        (wcnt < WW'(DEPTH)) && !host_cmd_vld;
  assign host_cmd_rdy = (state_q == ST_LOAD) &&
                        (bcnt == '0) && !core_busy;
  assign beat_en  = host_wr && host_rdy;
  assign cmd_fire = host_cmd_vld && host_cmd_rdy;

  assign op_cmd = auc_opcnt(host_cmd_mode);
  assign cmd_ok = op_cmd.legal && (wcnt == WW'(op_cmd.n));
  assign op_cur = auc_opcnt(mode_q);
  assign last3  = (op_cur.legal && op_cur.n != 3'd0) ?
                  op_cur.n - 3'd1 : 3'd0;
  assign klast  = IW'(last3);

  auc_wbuf #(
    .WIDTH (WIDTH),
    .BUS   (BUS),
    .DEPTH (DEPTH)
  ) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .beat_en  (beat_en),
    .beat_dat (host_wdat),
    .clr      (clr),
    .rd_idx   (rd_idx),
    .rd_dat   (rd_dat),
    .bcnt     (bcnt),
    .wcnt     (wcnt)
  );

  // next state: accept command, step burst index, count hold cycles
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    err_d   = err_q;
    dat_d   = dat_q;
    clr     = 1'b0;
    rd_idx  = kcnt_q + IW'(1);
    unique case (state_q)
      ST_LOAD: begin
        rd_idx = '0;
        if (cmd_fire) begin
          if (cmd_ok) begin
            state_d = ST_SEND;
            mode_d  = host_cmd_mode;
            err_d   = 1'b0;
            kcnt_d  = '0;
            dat_d   = (op_cmd.n == 3'd0) ? '0 : rd_dat;
          end else begin
            err_d = 1'b1;
            clr   = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (kcnt_q == klast) begin
          state_d = ST_HOLD;
          hold_d  = 1'b0;
        end else begin
          kcnt_d = kcnt_q + IW'(1);
          dat_d  = rd_dat;
        end
      end
      ST_HOLD: begin
        if (hold_q) begin
          state_d = ST_LOAD;
          clr     = 1'b1;
        end else begin
          hold_d = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      kcnt_q  <= '0;
      hold_q  <= 1'b0;
      mode_q  <= 3'b000;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign auc_start = (state_q == ST_SEND);
  assign ldr_busy  = (state_q != ST_LOAD);
  assign auc_dat   = dat_q;
  assign auc_mode  = mode_q;
  assign ldr_err   = err_q;

endmodule

// File: tb/tb_auc_loader.sv
// tb_auc_loader: directed and randomized checks of auc_loader
// against an operand-queue reference model.
module tb_auc_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         host_wr = 1'b0;
  logic [31:0]  host_wdat = '0;
  logic         host_rdy;
  logic         host_cmd_vld = 1'b0;
  logic [2:0]   host_cmd_mode = '0;
  logic         host_cmd_rdy;
  logic         core_busy = 1'b0;
  logic [255:0] auc_dat;
  logic         auc_start;
  logic [2:0]   auc_mode;
  logic         ldr_busy;
  logic         ldr_err;

  int pass_cnt = 0;
  int total    = 0;

  logic [255:0] mq[$];
  bit           err_m = 1'b0;

  auc_loader dut (
    .clk           (clk),
    .rst           (rst),
    .host_wr       (host_wr),
    .host_wdat     (host_wdat),
    .host_rdy      (host_rdy),
    .host_cmd_vld  (host_cmd_vld),
    .host_cmd_mode (host_cmd_mode),
    .host_cmd_rdy  (host_cmd_rdy),
    .core_busy     (core_busy),
    .auc_dat       (auc_dat),
    .auc_start     (auc_start),
    .auc_mode      (auc_mode),
    .ldr_busy      (ldr_busy),
    .ldr_err       (ldr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int exp_n(input logic [2:0] m);
    case (m)
      3'b011:  return 2;
      3'b101:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_legal(input logic [2:0] m);
    return !(m == 3'b100 || m == 3'b110 || m == 3'b111);
  endfunction

  function automatic logic [255:0] rnd_word();
    logic [255:0] w;
    for (int j = 0; j < 8; j++) w[32*j +: 32] = $urandom();
    return w;
  endfunction

  task automatic put_beat(input logic [31:0] d, input logic exp_rdy);
    @(negedge clk);
    host_wr   = 1'b1;
    host_wdat = d;
    #1 chk("host_rdy_beat", host_rdy, exp_rdy);
    @(posedge clk);
    #1 host_wr = 1'b0;
  endtask

  task automatic load_word(input logic [255:0] w);
    for (int i = 0; i < 8; i++) put_beat(w[32*i +: 32], 1'b1);
    mq.push_back(w);
  endtask

  task automatic do_cmd(input logic [2:0] m);
    int n;
    int mb;
    bit ok;
    n  = exp_n(m);
    ok = exp_legal(m) && (mq.size() == n);
    mb = (n == 0) ? 1 : n;
    @(negedge clk);
    chk("ldr_err_pre", ldr_err, err_m);
    host_cmd_vld  = 1'b1;
    host_cmd_mode = m;
    #1 chk("cmd_rdy", host_cmd_rdy, 1'b1);
    @(posedge clk);
    #1 host_cmd_vld = 1'b0;
    if (ok) begin
      for (int k = 0; k < mb; k++) begin
        @(negedge clk);
        chk("burst_start", auc_start, 1'b1);
        chk("burst_dat", auc_dat, (n == 0) ? 256'd0 : mq[k]);
        chk("burst_mode", auc_mode, m);
        chk("burst_busy", ldr_busy, 1'b1);
      end
      for (int h = 0; h < 2; h++) begin
        @(negedge clk);
        chk("hold_start", auc_start, 1'b0);
        chk("hold_mode", auc_mode, m);
        chk("hold_busy", ldr_busy, 1'b1);
      end
      @(negedge clk);
      chk("post_busy", ldr_busy, 1'b0);
      chk("post_rdy", host_rdy, 1'b1);
      chk("post_err", ldr_err, 1'b0);
      err_m = 1'b0;
    end else begin
      @(negedge clk);
      chk("err_start", auc_start, 1'b0);
      chk("err_flag", ldr_err, 1'b1);
      chk("err_busy", ldr_busy, 1'b0);
      chk("err_rdy", host_rdy, 1'b1);
      err_m = 1'b1;
    end
    mq.delete();
  endtask

  initial begin
    logic [255:0] w;
    logic [2:0]   m;
    int           nw;

    // reset values
    #2;
    chk("rst_dat", auc_dat, 256'd0);
    chk("rst_start", auc_start, 1'b0);
    chk("rst_mode", auc_mode, 3'b000);
    chk("rst_busy", ldr_busy, 1'b0);
    chk("rst_err", ldr_err, 1'b0);
    chk("rst_hrdy", host_rdy, 1'b1);
    chk("rst_crdy", host_cmd_rdy, 1'b1);
    core_busy = 1'b1;
    #1 chk("rst_crdy_busy", host_cmd_rdy, 1'b0);
    core_busy = 1'b0;
    #10 rst = 1'b1;

    // MMUL directed operands
    load_word(256'd0);
    load_word(256'd1);
    load_word(256'hAB);
    load_word(256'h1234);
    do_cmd(3'b101);

    // RAND with empty buffer: one dummy cycle
    do_cmd(3'b000);

    // S with one operand: error, then a correct S clears it
    load_word(rnd_word());
    do_cmd(3'b011);
    load_word(rnd_word());
    load_word(rnd_word());
    do_cmd(3'b011);

    // illegal mode
    do_cmd(3'b100);

    // partial word blocks commands
    w = rnd_word();
    for (int i = 0; i < 3; i++) put_beat(w[32*i +: 32], 1'b1);
    @(negedge clk);
    #1 chk("crdy_partial", host_cmd_rdy, 1'b0);
    for (int i = 3; i < 8; i++) put_beat(w[32*i +: 32], 1'b1);
    mq.push_back(w);
    core_busy = 1'b1;
    @(negedge clk);
    #1 chk("crdy_core_busy", host_cmd_rdy, 1'b0);

    // beat and command together: beat refused
    host_cmd_vld  = 1'b1;
    host_cmd_mode = 3'b011;
    host_wr       = 1'b1;
    host_wdat     = 32'hDEAD_BEEF;
    #1 chk("hrdy_with_cmd", host_rdy, 1'b0);
    @(posedge clk);
    #1;
    host_cmd_vld = 1'b0;
    host_wr      = 1'b0;
    core_busy    = 1'b0;
    load_word(rnd_word());
    do_cmd(3'b011);

    // full buffer refuses a fifth operand
    for (int i = 0; i < 4; i++) load_word(rnd_word());
    put_beat(32'hFFFF_FFFF, 1'b0);
    do_cmd(3'b101);

    // reset during MMUL burst cycle 2
    for (int i = 0; i < 4; i++) load_word(rnd_word());
    @(negedge clk);
    host_cmd_vld  = 1'b1;
    host_cmd_mode = 3'b101;
    @(posedge clk);
    #1 host_cmd_vld = 1'b0;
    @(negedge clk);
    chk("rb_dat0", auc_dat, mq[0]);
    @(negedge clk);
    chk("rb_dat1", auc_dat, mq[1]);
    @(negedge clk);
    chk("rb_start2", auc_start, 1'b1);
    chk("rb_dat2", auc_dat, mq[2]);
    rst = 1'b0;
    #1;
    chk("rb_start", auc_start, 1'b0);
    chk("rb_dat", auc_dat, 256'd0);
    chk("rb_mode", auc_mode, 3'b000);
    chk("rb_busy", ldr_busy, 1'b0);
    chk("rb_err", ldr_err, 1'b0);
    chk("rb_hrdy", host_rdy, 1'b1);
    mq.delete();
    err_m = 1'b0;
    #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) load_word(rnd_word());
    do_cmd(3'b101);

    // randomized command mix
    for (int it = 0; it < 30; it++) begin
      nw = $urandom_range(0, 4);
      for (int i = 0; i < nw; i++) load_word(rnd_word());
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        core_busy = 1'b1;
        #1 chk("rnd_crdy_busy", host_cmd_rdy, 1'b0);
        @(posedge clk);
        #1 core_busy = 1'b0;
      end
      m = 3'($urandom_range(0, 7));
      do_cmd(m);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/auc_loader.md
# auc_loader

Host-side command loader directly upstream of `auc_decoder`. It gathers 256-bit operands from a 32-bit host write port, checks them against the command mode, and plays them out as one contiguous `auc_start` burst. `auc_dat` carries operand k in the k-th burst cycle, and `auc_mode` is held until the decoder's falling-edge enable has fired. The loader frees the host from cycle-exact burst timing.

## Interface
- `WIDTH`, 256, operand width
- `BUS`, 32, host beat width; `WIDTH/BUS` = beats per operand (8)
- `DEPTH`, 4, maximum operands per command
- `clk` input 1, single clock
- `rst` input 1, asynchronous, active-low reset
- `host_wr` input 1, beat valid
- `host_wdat` input BUS, beat data; the first beat of an operand is bits [BUS-1:0] (LSW first)
- `host_rdy` output 1, beat accepted when `host_wr & host_rdy`
- `host_cmd_vld` input 1, command valid
- `host_cmd_mode` input 3, command mode
- `host_cmd_rdy` output 1, command accepted when `host_cmd_vld & host_cmd_rdy`
- `core_busy` input 1, core still executing the previous command
- `auc_dat` output WIDTH, operand to the decoder
- `auc_start` output 1, burst strobe to the decoder
- `auc_mode` output 3, mode to the decoder
- `ldr_busy` output 1, high in SEND/HOLD
- `ldr_err` output 1, sticky error flag; cleared by the next accepted legal command

## Operation
- Operand counts N per mode:
  - RAND 000, INVS 001, R 010: N = 0 operands, but the burst is 1 dummy cycle with `auc_dat` = 0.
  - S 011: N = 2 (HASH, PKEY).
  - MMUL 101: N = 4 (ZRRAM, ONERAM, X_G, K_NUM).
  - 100, 110, 111: illegal.
- States:
  - **LOAD** (reset state). Beats fill a shift/assembly register. Beat counter `bcnt` runs 0..7; on the 8th beat the word goes into `buf[wcnt]` and `wcnt` increments.
  - **SEND**. Burst cycle k (0..max(N,1)-1) drives `auc_start`=1 and `auc_dat`=`buf[k]` (or 0 for the dummy).
  - **HOLD**. Exactly 2 cycles with `auc_start`=0 and `auc_mode` still held; then return to LOAD with `wcnt`=`bcnt`=0.
- Flow control:
  - `host_rdy` = LOAD & (`wcnt` < `DEPTH`) & ~`host_cmd_vld`. When a command and a beat arrive in the same cycle, the command wins and the beat is not taken.
  - `host_cmd_rdy` = LOAD & (`bcnt` == 0) & ~`core_busy`.
- Command acceptance:
  - Legal mode with `wcnt` == N: latch `auc_mode`, go to SEND, clear `ldr_err`.
  - Illegal mode, or `wcnt` ≠ N: set `ldr_err`, clear the buffer, stay in LOAD, no burst.
- Beats with `host_wr` while `host_rdy`=0 are ignored. Buffer contents are never partially overwritten.
- Reset asserted mid-burst: all state clears at once and `auc_start` drops asynchronously. The decoder may see a truncated burst; that is acceptable and is recovered by software.

## Timing
- Reset values:
  - `auc_dat` = 0, `auc_start` = 0, `auc_mode` = 000
  - `ldr_busy` = 0, `ldr_err` = 0
  - `host_rdy` = 1, `host_cmd_rdy` = ~`core_busy`
- Command accepted at edge T:
  - `auc_start` is high for cycles T+1..T+M, where M = max(N,1).
  - `auc_mode` is stable T+1..T+M+2, covering the decoder's `neg_start` in cycle T+M+2.
  - `auc_dat` is registered and changes only at burst-cycle boundaries.
  - HOLD covers T+M+1 and T+M+2. LOAD resumes at T+M+3; `host_rdy` is 1 that cycle.
- Full operand: 8 accepted beats. `wcnt` increments on the edge of the 8th beat.
- `core_busy` is sampled combinationally into `host_cmd_rdy` only; it does not stall a burst in progress.

## Structure
- Shared package `auc_pkg` holds:
  - mode constants (RAND..MMUL)
  - `auc_opcnt(mode)` function returning N and a legal flag
  - beats-per-word constant
- These constants are shared with `auc_decoder`.
- Sub-module `auc_wbuf` holds the beat assembly register, `bcnt`/`wcnt`, and the `DEPTH`×`WIDTH` operand buffer, with a read index port. The FSM stays in `auc_loader`.

## Test plan
- **MMUL load and burst:** load 4 operands with word0 = 0, word1 = 1, word2 = 0x…AB, word3 = 0x…1234, then issue MMUL → `auc_start` high exactly 4 cycles; `auc_dat` shows 0, 1, 0x…AB, 0x…1234 in order; `auc_mode` = 101 held 2 cycles after the fall; decoder `dec_ranvld` fires with 0x…1234.
- **RAND, no operands:** RAND with `wcnt` = 0 → 1-cycle burst with `auc_dat` = 0; `en_rand` pulses once.
- **S count mismatch:** S issued after only 1 operand → `ldr_err` = 1, no `auc_start`, buffer empty; a following correct S clears `ldr_err`.
- **Illegal mode:** mode 100 → `ldr_err` = 1, no burst; `host_cmd_rdy` low when `bcnt` = 3 (partial word) or when `core_busy` = 1.
- **Simultaneous beat and command:** `host_wr` and `host_cmd_vld` in the same cycle → beat not accepted; a 5th operand on a full buffer → `host_rdy` = 0, data unchanged.
- **Reset mid-burst:** `rst` low at MMUL burst cycle 2 → `auc_start` = 0 immediately, all outputs at reset values; a clean MMUL after release succeeds.
